// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared widths and entry type for the regfile writeback queue.
// Revision : 1.0
// ============================================================================
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : In-order DEPTH-entry store exposing every slot, its validity and
//            the slot index of each age (order[0] is the oldest entry).
// Revision : 1.0
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    output wb_entry_t                    head,
    output wb_entry_t                    entries [DEPTH],
    output logic [DEPTH-1:0]             valid,
    output logic [$clog2(DEPTH)-1:0]     order   [DEPTH],
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    wb_entry_t            r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic w_push;
    logic w_pop;

    // Occupancy alone separates full from empty; the pointers just wrap.
    assign w_push = push && (r_count != c_cnt_w'(DEPTH));
    assign w_pop  = pop  && (r_count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= push_entry;
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            logic [c_ptr_w-1:0] w_age;
            assign w_age      = c_ptr_w'(i) - r_rd_ptr;
            assign valid[i]   = c_cnt_w'(w_age) < r_count;
            assign order[i]   = r_rd_ptr + c_ptr_w'(i);
            assign entries[i] = r_mem[i];
        end
    endgenerate

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_queue
// Purpose  : Buffers completed results and retires one per cycle into the
//            register file write port; flags pending writes for decode.
//            Define WB_BYPASS_EN to build youngest-match data forwarding.
// Revision : 1.0
// ============================================================================
module regfile_wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [REG_ADDR_W-1:0]       in_rd,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        hold,
    output logic                        wEn,
    output logic [REG_ADDR_W-1:0]       write_sel,
    output logic [DATA_W-1:0]           write_data,
    input  logic [REG_ADDR_W-1:0]       rs1,
    input  logic [REG_ADDR_W-1:0]       rs2,
    output logic                        pend1,
    output logic                        pend2,
    output logic [DATA_W-1:0]           fwd1_data,
    output logic [DATA_W-1:0]           fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    wb_entry_t           w_head;
    wb_entry_t           w_entries [DEPTH];
    logic [DEPTH-1:0]    w_valid;
    logic [c_ptr_w-1:0]  w_order   [DEPTH];
    logic                w_push;
    logic                w_pop;
    logic                w_hit1;
    logic                w_hit2;

    assign in_ready = (count != ($clog2(DEPTH+1))'(DEPTH));
    // x0 results are acknowledged but never stored.
    assign w_push   = in_valid && in_ready && (in_rd != '0);
    assign w_pop    = (count != '0) && !hold;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (w_push),
        .push_entry ('{rd: in_rd, data: in_data}),
        .pop        (w_pop),
        .head       (w_head),
        .entries    (w_entries),
        .valid      (w_valid),
        .order      (w_order),
        .count      (count)
    );

    assign wEn        = w_pop;
    assign write_sel  = w_pop ? w_head.rd   : '0;
    assign write_data = w_pop ? w_head.data : '0;

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_entries[i].rd == rs1)) w_hit1 = 1'b1;
            if (w_valid[i] && (w_entries[i].rd == rs2)) w_hit2 = 1'b1;
        end
    end

    assign pend1 = w_hit1 && (rs1 != '0);
    assign pend2 = w_hit2 && (rs2 != '0);

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd1_data = '0;
        fwd2_data = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (w_valid[w_order[a]] && (w_entries[w_order[a]].rd == rs1) && (rs1 != '0))
                fwd1_data = w_entries[w_order[a]].data;
            if (w_valid[w_order[a]] && (w_entries[w_order[a]].rd == rs2) && (rs2 != '0))
                fwd2_data = w_entries[w_order[a]].data;
        end
    end
`else
    logic [DEPTH-1:0] w_unused_fwd;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_unused
            assign w_unused_fwd[i] = ^{w_entries[i].data, w_order[i]};
        end
    endgenerate

    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_queue
// Purpose  : Self-checking bench for regfile_wb_queue against a queue model.
// Revision : 1.0
// ============================================================================
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        hold;
    logic        wEn;
    logic [4:0]  write_sel;
    logic [31:0] write_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        pend1;
    logic        pend2;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [2:0]  count;

    int n_vec;
    int n_err;
    int retired;

    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    logic [31:0] rf_model [32];
    logic [31:0] rf_dut   [32];

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .hold       (hold),
        .wEn        (wEn),
        .write_sel  (write_sel),
        .write_data (write_data),
        .rs1        (rs1),
        .rs2        (rs2),
        .pend1      (pend1),
        .pend2      (pend2),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected outputs from the queue contents
    function automatic logic exp_pend(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        foreach (q_rd[i]) if (q_rd[i] == rs) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_fwd(input logic [4:0] rs);
`ifdef WB_BYPASS_EN
        if (rs == 5'd0) return 32'd0;
        for (int i = q_rd.size() - 1; i >= 0; i--)
            if (q_rd[i] == rs) return q_data[i];
`endif
        return 32'd0;
    endfunction

    function automatic logic exp_wen();
        return (q_rd.size() > 0) && !hold;
    endfunction

    function automatic logic [4:0] exp_sel();
        return exp_wen() ? q_rd[0] : 5'd0;
    endfunction

    function automatic logic [31:0] exp_data();
        return exp_wen() ? q_data[0] : 32'd0;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic h, input logic [4:0] r1, input logic [4:0] r2);
        in_valid = v; in_rd = rd; in_data = d; hold = h; rs1 = r1; rs2 = r2;
    endtask

    // Advance one clock: mirror the DUT write port into a register file and
    // apply the same edge to the model.
    task automatic tick();
        logic acc;
        if (!reset && wEn === 1'b1) rf_dut[write_sel] = write_data;
        if (reset) begin
            q_rd.delete();
            q_data.delete();
        end else begin
            acc = in_valid && (q_rd.size() < DEPTH);
            if (q_rd.size() > 0 && !hold) begin
                rf_model[q_rd[0]] = q_data[0];
                void'(q_rd.pop_front());
                void'(q_data.pop_front());
                retired++;
            end
            if (acc && in_rd != 5'd0) begin
                q_rd.push_back(in_rd);
                q_data.push_back(in_data);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd2);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_vec++; if (count !== 3'd0)      begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_vec++; if ({wEn, write_sel, write_data} !== 38'd0)
                                          begin n_err++; $display("FAIL reset_wport: got %b/%h/%h want 0", wEn, write_sel, write_data); end
        n_vec++; if ({pend1, pend2, fwd1_data, fwd2_data} !== 66'd0)
                                          begin n_err++; $display("FAIL reset_pend: got %b%b %h %h want 0", pend1, pend2, fwd1_data, fwd2_data); end
    endtask

    task automatic test_reset_flush();
        for (int i = 2; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'hA000_0000 + 32'(i), 1'b1, 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        #1;
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_fill: got %0d want 3", count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        #1;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
        n_vec++; if (wEn !== 1'b0)   begin n_err++; $display("FAIL flush_wen: got %b want 0", wEn); end
        tick();
        tick();
        for (int i = 2; i <= 4; i++) begin
            n_vec++;
            if (rf_dut[i] !== 32'd0) begin n_err++; $display("FAIL flush_rf x%0d: got %h want 0", i, rf_dut[i]); end
        end
    endtask

    task automatic test_single_write();
        drive(1'b1, 5'd2, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        #1;
        n_vec++; if ({wEn, write_sel, write_data} !== {1'b1, 5'd2, 32'hDEADBEEF})
                     begin n_err++; $display("FAIL single_wport: got %b/%0d/%h want 1/2/deadbeef", wEn, write_sel, write_data); end
        tick();
        #1;
        n_vec++; if (rf_dut[2] !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rf: got %h want deadbeef", rf_dut[2]); end
        n_vec++; if (wEn !== 1'b0)               begin n_err++; $display("FAIL single_idle: got %b want 0", wEn); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'hF000_0000 + 32'(i), 1'b1, 5'd0, 5'd0);
            tick();
        end
        drive(1'b1, 5'd9, 32'hBAD0_0009, 1'b1, 5'd0, 5'd0);
        #1;
        n_vec++; if (count !== 3'd4)    begin n_err++; $display("FAIL full_count: got %0d want 4", count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", in_ready); end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_vec++;
            if ({wEn, write_sel, write_data} !== {1'b1, 5'(i), 32'hF000_0000 + 32'(i)})
                begin n_err++; $display("FAIL full_drain x%0d: got %b/%0d/%h", i, wEn, write_sel, write_data); end
            tick();
        end
        #1;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL full_empty: got %0d want 0", count); end
    endtask

    task automatic test_x0_drop();
        drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", in_ready); end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        #1;
        n_vec++; if ({count, wEn} !== 4'd0) begin n_err++; $display("FAIL x0_drop: got count %0d wEn %b want 0/0", count, wEn); end
        tick();
    endtask

    task automatic test_hazard();
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd5, 32'h22, 1'b1, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6);
        #1;
        n_vec++; if ({pend1, pend2} !== 2'b10) begin n_err++; $display("FAIL hazard_pend: got %b%b want 10", pend1, pend2); end
        n_vec++; if (fwd1_data !== exp_fwd(5'd5)) begin n_err++; $display("FAIL hazard_fwd1: got %h want %h", fwd1_data, exp_fwd(5'd5)); end
        n_vec++; if (fwd2_data !== 32'd0) begin n_err++; $display("FAIL hazard_fwd2: got %h want 0", fwd2_data); end
        hold = 1'b0;
        tick();
        #1;
        n_vec++; if ({pend1, fwd1_data} !== {1'b1, exp_fwd(5'd5)})
                     begin n_err++; $display("FAIL hazard_last: got %b/%h want 1/%h", pend1, fwd1_data, exp_fwd(5'd5)); end
        tick();
        #1;
        n_vec++; if ({pend1, fwd1_data} !== 33'd0) begin n_err++; $display("FAIL hazard_clear: got %b/%h want 0", pend1, fwd1_data); end
    endtask

    task automatic test_back_to_back();
        int start;
        start = retired;
        for (int i = 0; i < 11; i++) begin
            if (i < 10) drive(1'b1, 5'(i + 10), $urandom, 1'b0, 5'd0, 5'd0);
            else        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
            #1;
            n_vec++; if (count > 3'd1) begin n_err++; $display("FAIL b2b_count: got %0d want <=1", count); end
            n_vec++; if ({wEn, write_sel, write_data} !== {exp_wen(), exp_sel(), exp_data()})
                         begin n_err++; $display("FAIL b2b_wport: got %b/%0d/%h want %b/%0d/%h",
                                                 wEn, write_sel, write_data, exp_wen(), exp_sel(), exp_data()); end
            tick();
        end
        n_vec++; if (retired - start != 10) begin n_err++; $display("FAIL b2b_retired: got %0d want 10", retired - start); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            n_vec++; if ({count, in_ready} !== {3'(q_rd.size()), q_rd.size() < DEPTH})
                         begin n_err++; $display("FAIL rnd_count c%0d: got %0d/%b want %0d", c, count, in_ready, q_rd.size()); end
            n_vec++; if ({wEn, write_sel, write_data} !== {exp_wen(), exp_sel(), exp_data()})
                         begin n_err++; $display("FAIL rnd_wport c%0d: got %b/%0d/%h want %b/%0d/%h",
                                                 c, wEn, write_sel, write_data, exp_wen(), exp_sel(), exp_data()); end
            n_vec++; if ({pend1, pend2} !== {exp_pend(rs1), exp_pend(rs2)})
                         begin n_err++; $display("FAIL rnd_pend c%0d: got %b%b want %b%b", c, pend1, pend2, exp_pend(rs1), exp_pend(rs2)); end
            n_vec++; if ({fwd1_data, fwd2_data} !== {exp_fwd(rs1), exp_fwd(rs2)})
                         begin n_err++; $display("FAIL rnd_fwd c%0d: got %h %h want %h %h", c, fwd1_data, fwd2_data, exp_fwd(rs1), exp_fwd(rs2)); end
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        for (int i = 0; i < DEPTH + 1; i++) tick();
        for (int r = 1; r < 32; r++) begin
            n_vec++;
            if (rf_dut[r] !== rf_model[r]) begin n_err++; $display("FAIL rnd_rf x%0d: got %h want %h", r, rf_dut[r], rf_model[r]); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        retired = 0;
        for (int r = 0; r < 32; r++) begin
            rf_model[r] = 32'd0;
            rf_dut[r]   = 32'd0;
        end
        test_reset();
        test_reset_flush();
        test_single_write();
        test_full();
        test_x0_drop();
        test_hazard();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
